// File: rtl/logic_unit_pkg.sv
// Shared op encoding and bitwise evaluation for the pipelined logic unit.
package logic_unit_pkg;

  localparam int LOGIC_MAX_W = 64;

  typedef logic [2:0] logic_op_t;

  localparam logic_op_t LOGIC_OP_AND   = 3'b000;
  localparam logic_op_t LOGIC_OP_OR    = 3'b001;
  localparam logic_op_t LOGIC_OP_XOR   = 3'b010;
  localparam logic_op_t LOGIC_OP_NOR   = 3'b011;
  localparam logic_op_t LOGIC_OP_ANDN  = 3'b100;
  localparam logic_op_t LOGIC_OP_ORN   = 3'b101;
  localparam logic_op_t LOGIC_OP_PASSA = 3'b110;
  localparam logic_op_t LOGIC_OP_PASSB = 3'b111;

  // Operands are zero-extended to LOGIC_MAX_W; callers keep the low bits.
  function automatic logic [LOGIC_MAX_W-1:0] logic_eval(
    input logic_op_t              op,
    input logic [LOGIC_MAX_W-1:0] a,
    input logic [LOGIC_MAX_W-1:0] b
  );
    logic [LOGIC_MAX_W-1:0] r;
    r = '0;
    unique case (op)
      LOGIC_OP_AND:   r = a & b;
      LOGIC_OP_OR:    r = a | b;
      LOGIC_OP_XOR:   r = a ^ b;
      LOGIC_OP_NOR:   r = ~(a | b);
      LOGIC_OP_ANDN:  r = a & ~b;
      LOGIC_OP_ORN:   r = a | ~b;
      LOGIC_OP_PASSA: r = a;
      LOGIC_OP_PASSB: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register slice carrying a result payload.
module logic_pipe_stage
  import logic_unit_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         dn_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         open;

  assign open = !valid_q || dn_ready;

  // Data only moves on a real load so the output holds when idle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (open) valid_d = up_valid;
    if (open && up_valid) data_d = up_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit logic unit with valid/ready handshake and zero flag.
// Define LOGIC_UNIT_PIPE_PARITY_EN to add the out_parity output.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif

  logic [LOGIC_MAX_W-1:0] full;
  logic [WIDTH-1:0]       res;
  logic                   unused_bits;
  logic [PW-1:0]          pd [LATENCY+1];
  logic [LATENCY-1:0]     vq;
  logic [LATENCY:0]       rdy;

  assign full        = logic_eval(in_op, LOGIC_MAX_W'(in_a), LOGIC_MAX_W'(in_b));
  assign res         = full[WIDTH-1:0];
  assign unused_bits = ^full;

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  assign pd[0] = {^res, res == '0, res};
`else
  assign pd[0] = {res == '0, res};
`endif

  // Flattened ready chain: a stage can move if any stage at or after
  // it is empty, or the consumer is taking the head.
  always_comb begin
    logic acc;
    rdy = '0;
    for (int k = 0; k <= LATENCY; k++) begin
      acc = out_ready;
      for (int j = k; j < LATENCY; j++) acc = acc | !vq[j];
      rdy[k] = acc;
    end
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic up_v;
    if (k == 0) begin : g_first
      assign up_v = in_valid;
    end else begin : g_next
      assign up_v = vq[k-1];
    end
    logic_pipe_stage #(.W(PW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_v),
      .up_data  (pd[k]),
      .dn_ready (rdy[k+1]),
      .dn_valid (vq[k]),
      .dn_data  (pd[k+1])
    );
  end

  assign in_ready   = rdy[0];
  assign out_valid  = vq[LATENCY-1];
  assign out_result = pd[LATENCY][WIDTH-1:0];
  assign out_zero   = pd[LATENCY][WIDTH];
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  assign out_parity = pd[LATENCY][WIDTH+1];
`endif

endmodule
